// File: rtl/pong_input_conditioner.sv
// pong_input_conditioner: pad conditioning for the pong VGA core.
// Synchronises five raw pushbuttons, debounces each one with a tick-sampled
// saturating integrator with hysteresis, and drives registered debounced levels
// plus one-cycle press pulses. btn_press[4] doubles as the score_reset pulse.
// Optional build macro: PONG_OPPOSE_LOCKOUT_EN -- when defined, an up/down pair
// whose debounced states are both high is forced to 0 on btn_level.
module pong_input_conditioner #(
  parameter int CLK_HZ           = 25175000,
  parameter int TICK_HZ          = 1000,
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [4:0] btn_press,
  output logic       score_reset_pulse,
  output logic       tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  // tick is registered, so it is set one count early to line up with TICK_LAST
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [4:0]        sync1_r;
  logic [4:0]        sync2_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_r;
  logic [CNT_W-1:0]  cnt_r     [5];
  logic [CNT_W-1:0]  cnt_nxt_s [5];
  logic [4:0]        d_r;
  logic [4:0]        d_nxt_s;
  logic [4:0]        d_prev_r;
  logic [3:0]        level_r;
  logic [3:0]        level_nxt_s;
  logic [4:0]        press_r;

  // Two-flop synchroniser on every raw pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Sample-rate divider; tick_r is high while the counter sits at TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      tick_r     <= 1'b0;
    end else begin
      if (tick_cnt_r == TICK_LAST) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
      tick_r <= (tick_cnt_r == TICK_PRE);
    end
  end

  // Saturating integrator and hysteresis decision, evaluated only on ticks
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      d_nxt_s[i]   = d_r[i];
      if (tick_r) begin
        if (sync2_r[i] && (cnt_r[i] < CNT_MAX)) begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end else if (!sync2_r[i] && (cnt_r[i] > CNT_ZERO)) begin
          cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
        end else begin
          cnt_nxt_s[i] = cnt_r[i];
        end
        if (cnt_nxt_s[i] == CNT_MAX) begin
          d_nxt_s[i] = 1'b1;
        end else if (cnt_nxt_s[i] == CNT_ZERO) begin
          d_nxt_s[i] = 1'b0;
        end else begin
          d_nxt_s[i] = d_r[i];
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
        d_nxt_s[i]   = d_r[i];
      end
    end
  end

  // Integrator and debounced-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      d_r <= 5'b00000;
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      d_r <= d_nxt_s;
    end
  end

  // Paddle level selection, with optional suppression of opposing pairs
  always_comb begin
    level_nxt_s = d_r[3:0];
`ifdef PONG_OPPOSE_LOCKOUT_EN
    if (d_r[1:0] == 2'b11) begin
      level_nxt_s[1:0] = 2'b00;
    end else begin
      level_nxt_s[1:0] = d_r[1:0];
    end
    if (d_r[3:2] == 2'b11) begin
      level_nxt_s[3:2] = 2'b00;
    end else begin
      level_nxt_s[3:2] = d_r[3:2];
    end
`endif
  end

  // Registered outputs: levels and rising-edge press pulses share one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev_r <= 5'b00000;
      level_r  <= 4'b0000;
      press_r  <= 5'b00000;
    end else begin
      d_prev_r <= d_r;
      level_r  <= level_nxt_s;
      press_r  <= d_r & ~d_prev_r;
    end
  end

  assign btn_level         = level_r;
  assign btn_press         = press_r;
  assign score_reset_pulse = press_r[4];
  assign tick              = tick_r;

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Directed bench for pong_input_conditioner with TICK_DIV=10, DEBOUNCE_SAMPLES=4.
// Time reference: cyc counts rising edges since reset release; outputs are
// sampled on the falling edge after edge cyc. Integrator updates land on edges
// 10, 20, 30, ...; a raw change made after edge c is visible to ticks from c+3.
module tb_pong_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [3:0] btn_level;
  logic [4:0] btn_press;
  logic       score_reset_pulse;
  logic       tick;

  int checks;
  int failures;
  int cyc;

`ifdef PONG_OPPOSE_LOCKOUT_EN
  localparam logic [3:0] PAIR_EXP = 4'h0;
`else
  localparam logic [3:0] PAIR_EXP = 4'h3;
`endif

  pong_input_conditioner #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .DEBOUNCE_SAMPLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .score_reset_pulse(score_reset_pulse),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [3:0] lvl_exp, input logic [4:0] press_exp);
    check({name, ".level"}, {28'd0, btn_level}, {28'd0, lvl_exp});
    check({name, ".press"}, {27'd0, btn_press}, {27'd0, press_exp});
    check({name, ".srp"}, {31'd0, score_reset_pulse}, {31'd0, press_exp[4]});
    check({name, ".tick"}, {31'd0, tick}, {31'd0, (cyc % 10 == 9)});
  endtask

  task automatic do_reset(input logic [4:0] raw);
    btn_raw = raw;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    logic [5:0] pat;
    clk      = 1'b0;
    rst_n    = 1'b0;
    btn_raw  = 5'h00;
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // Reset: all held from release, levels at edge 41; then async reset mid-run
    do_reset(5'h1F);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 45; k++) begin
        step();
        chk("rst_run", (cyc >= 41) ? 4'hF : 4'h0, (cyc == 41) ? 5'h1F : 5'h00);
      end
      if (pass == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.level", {28'd0, btn_level}, 32'd0);
        check("async_rst.press", {27'd0, btn_press}, 32'd0);
        check("async_rst.srp", {31'd0, score_reset_pulse}, 32'd0);
        check("async_rst.tick", {31'd0, tick}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
      end
    end

    // Clean press on bit 0 with a one-sample dropout, then release
    do_reset(5'h00);
    for (int k = 0; k < 115; k++) begin
      step();
      chk("press0", (cyc >= 51 && cyc < 111) ? 4'h1 : 4'h0, (cyc == 51) ? 5'h01 : 5'h00);
      if (cyc == 13) btn_raw[0] = 1'b1;
      if (cyc == 56) btn_raw[0] = 1'b0;
      if (cyc == 62) btn_raw[0] = 1'b1;
      if (cyc == 70) btn_raw[0] = 1'b0;
    end

    // Glitch on bit 2: high over edges 7..9, seen by the edge-10 tick only
    do_reset(5'h00);
    for (int k = 0; k < 45; k++) begin
      step();
      chk("glitch2", 4'h0, 5'h00);
      if (cyc == 6) btn_raw[2] = 1'b1;
      if (cyc == 9) btn_raw[2] = 1'b0;
    end

    // Chatter on bit 3: samples 1,1,0,1,1,1 -> cnt 1,2,1,2,3,4, rise at edge 60
    do_reset(5'h00);
    pat = 6'b111011;
    for (int k = 0; k < 75; k++) begin
      step();
      chk("chatter3", (cyc >= 61) ? 4'h8 : 4'h0, (cyc == 61) ? 5'h08 : 5'h00);
      if ((cyc % 10 == 5) && (cyc < 60)) btn_raw[3] = pat[cyc / 10];
    end

    // Score reset held for 10 ticks: one pulse, nothing on release
    do_reset(5'h10);
    for (int k = 0; k < 150; k++) begin
      step();
      chk("score", 4'h0, (cyc == 41) ? 5'h10 : 5'h00);
      if (cyc == 100) btn_raw[4] = 1'b0;
    end

    // Opposing left pair held, then left_up dropped (d[0] falls at edge 90)
    do_reset(5'h03);
    for (int k = 0; k < 100; k++) begin
      step();
      chk("pair", (cyc < 41) ? 4'h0 : ((cyc < 91) ? PAIR_EXP : 4'h2),
          (cyc == 41) ? 5'h03 : 5'h00);
      if (cyc == 50) btn_raw[0] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
